// File: rtl/vcode_chk.sv
// RX verification-code checker: recomputes the per-frame CRC, strips the tail id/CRC field,
// issues pass/fail verdicts and tracks the expected data-frame id. Optional error counter: VCODE_CHK_ERR_CNT_EN.
module vcode_chk #(
    parameter int                   FRAME_WIDTH    = 256,
    parameter int                   DWIDTH         = 64,
    parameter int                   CRC_WIDTH      = 12,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY       = 12'h02f,
    parameter int                   FRAME_ID_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_vld,
    input  logic                      sof,
    input  logic [DWIDTH-1:0]         data_in,
    output logic [DWIDTH-1:0]         data_out,
    output logic                      vld_out,
    output logic                      sof_out,
    output logic                      frame_ok,
    output logic                      frame_err,
    output logic                      retry_req,
    output logic [FRAME_ID_WIDTH-1:0] exp_id,
    output logic [15:0]               err_cnt
);
    localparam int N      = FRAME_WIDTH / DWIDTH;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam bit SINGLE = (N == 1);

    typedef enum logic {ST_OK, ST_RETRY} state_t;

    state_t                    state_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic [CRC_WIDTH-1:0]      crc_reg;
    logic                      is_data_reg;
    logic [FRAME_ID_WIDTH-1:0] exp_id_reg;
    logic [DWIDTH-1:0]         data_out_reg;
    logic                      vld_out_reg;
    logic                      sof_out_reg;
    logic                      frame_ok_reg;
    logic                      frame_err_reg;

    // MSB-first bit-serial CRC over one beat
    function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] crc_in,
                                                      input logic [DWIDTH-1:0]    d);
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c = crc_in;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ d[i];
            c  = {c[CRC_WIDTH-2:0], fb} ^ ({CRC_POLY[CRC_WIDTH-1:1], 1'b0} & {CRC_WIDTH{fb}});
        end
        return c;
    endfunction

    logic [DWIDTH-1:0] tail_mask;
    for (genvar gi = 0; gi < DWIDTH; gi++) begin : g_mask
        assign tail_mask[gi] = (gi >= CRC_WIDTH);
    end

    logic                      in_frame;
    logic                      is_last_cnt;
    logic                      is_tail;
    logic                      hdr_data;
    logic                      frame_data;
    logic                      tail_chk;
    logic                      pass;
    logic                      ok_next;
    logic                      err_next;
    logic [DWIDTH-1:0]         masked_data;
    logic [DWIDTH-1:0]         beat_data;
    logic [CRC_WIDTH-1:0]      crc_seed;
    logic [CRC_WIDTH-1:0]      crc_calc;
    logic [CRC_WIDTH-1:0]      exp_id_ext;
    logic [CNT_W-1:0]          cnt_next;

    assign in_frame    = (cnt_reg != '0);
    assign is_last_cnt = (cnt_reg == CNT_W'(N - 1));
    assign is_tail     = sof ? SINGLE : is_last_cnt;
    assign hdr_data    = (data_in[DWIDTH-1 -: 2] == 2'b01);
    assign frame_data  = sof ? hdr_data : is_data_reg;
    assign masked_data = data_in & tail_mask;
    assign beat_data   = is_tail ? masked_data : data_in;
    // Non-data frames are covered by the tail beat alone, so their CRC restarts there
    assign crc_seed    = (sof || (is_tail && !frame_data)) ? '0 : crc_reg;
    assign crc_calc    = crc_step(crc_seed, beat_data);
    assign tail_chk    = data_vld && (sof || in_frame) && is_tail;
    assign pass        = (data_in[CRC_WIDTH-1:0] == (crc_calc ^ exp_id_ext));
    assign ok_next     = tail_chk && pass;
    // An abort can never coincide with a tail check: a mid-frame sof only exists when N > 1
    assign err_next    = (data_vld && sof && in_frame) || (tail_chk && !pass);

    always_comb begin
        exp_id_ext = '0;
        exp_id_ext[FRAME_ID_WIDTH-1:0] = exp_id_reg;
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (data_vld) begin
            if (sof) begin
                cnt_next = SINGLE ? '0 : CNT_W'(1);
            end else if (in_frame) begin
                cnt_next = is_last_cnt ? '0 : cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_OK;
            cnt_reg       <= '0;
            crc_reg       <= '0;
            is_data_reg   <= 1'b0;
            exp_id_reg    <= '0;
            data_out_reg  <= '0;
            vld_out_reg   <= 1'b0;
            sof_out_reg   <= 1'b0;
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            vld_out_reg   <= data_vld;
            sof_out_reg   <= data_vld && sof;
            frame_ok_reg  <= ok_next;
            frame_err_reg <= err_next;
            cnt_reg       <= cnt_next;
            if (data_vld) begin
                data_out_reg <= tail_chk ? masked_data : data_in;
            end
            if (data_vld && (sof || in_frame)) begin
                crc_reg <= crc_calc;
            end
            if (data_vld && sof) begin
                is_data_reg <= hdr_data;
            end
            if (err_next) begin
                state_reg <= ST_RETRY;
            end else if (ok_next && frame_data) begin
                state_reg  <= ST_OK;
                exp_id_reg <= exp_id_reg + 1'b1;
            end
        end
    end

    assign data_out  = data_out_reg;
    assign vld_out   = vld_out_reg;
    assign sof_out   = sof_out_reg;
    assign frame_ok  = frame_ok_reg;
    assign frame_err = frame_err_reg;
    assign retry_req = (state_reg == ST_RETRY);
    assign exp_id    = exp_id_reg;

`ifdef VCODE_CHK_ERR_CNT_EN
    logic [15:0] err_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if (err_next && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign err_cnt = err_cnt_reg;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_vcode_chk.sv
// Bench for vcode_chk: frames built by a generator model, verdicts predicted at frame level
// with CRC computed as polynomial long division of the whole message.
module tb_vcode_chk;
    localparam int               DW   = 64;
    localparam logic [11:0]      POLY = 12'h02f;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_vld = 1'b0;
    logic          sof = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          vld_out;
    logic          sof_out;
    logic          frame_ok;
    logic          frame_err;
    logic          retry_req;
    logic [7:0]    exp_id;
    logic [15:0]   err_cnt;

    vcode_chk dut (
        .clk       (clk),
        .rst       (rst),
        .data_vld  (data_vld),
        .sof       (sof),
        .data_in   (data_in),
        .data_out  (data_out),
        .vld_out   (vld_out),
        .sof_out   (sof_out),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .retry_req (retry_req),
        .exp_id    (exp_id),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  m_exp_id = '0;
    bit          m_retry  = 1'b0;
    int          m_err_cnt = 0;
    bit          m_abort_pending = 1'b0;
    bit          wrapped = 1'b0;
    logic [63:0] fr [4];
    logic [63:0] saved [4];

    // Remainder of M(x)*x^12 divided by x^12 + POLY
    function automatic logic [11:0] crc_div(input logic [255:0] msg);
        logic [267:0] r;
        r = {msg, 12'b0};
        for (int i = 267; i >= 12; i--) begin
            if (r[i]) r[i -: 13] = r[i -: 13] ^ {1'b1, POLY};
        end
        return r[11:0];
    endfunction

    function automatic logic [11:0] frame_crc();
        logic [63:0] tail;
        tail = fr[3] & ~64'hFFF;
        if (fr[0][63:62] == 2'b01) return crc_div({fr[0], fr[1], fr[2], tail});
        return crc_div({192'b0, tail});
    endfunction

    task automatic build_frame(input logic [1:0] hdr, input logic [7:0] id);
        for (int b = 0; b < 4; b++) fr[b] = {$urandom, $urandom};
        fr[0][63:62] = hdr;
        fr[3][11:0]  = frame_crc() ^ {4'b0, id};
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_outs(input bit vld, input bit s, input logic [63:0] d,
                              input bit ok, input bit err);
        logic [15:0] cnt_exp;
`ifdef VCODE_CHK_ERR_CNT_EN
        cnt_exp = 16'(m_err_cnt);
`else
        cnt_exp = 16'h0;
`endif
        chk("vld_out", vld_out, vld);
        chk("sof_out", sof_out, s);
        if (vld) chk("data_out", data_out, d);
        chk("frame_ok", frame_ok, ok);
        chk("frame_err", frame_err, err);
        chk("retry_req", retry_req, m_retry);
        chk("exp_id", exp_id, m_exp_id);
        chk("err_cnt", err_cnt, cnt_exp);
    endtask

    task automatic beat(input bit s, input logic [63:0] d, input bit tail,
                        input bit ok, input bit err, input bit is_data);
        data_vld = 1'b1;
        sof      = s;
        data_in  = d;
        @(posedge clk);
        #1;
        data_vld = 1'b0;
        sof      = 1'b0;
        if (ok && is_data) begin
            if (m_exp_id == 8'hFF) wrapped = 1'b1;
            m_exp_id = m_exp_id + 8'd1;
            m_retry  = 1'b0;
        end
        if (err) begin
            m_retry = 1'b1;
            if (m_err_cnt < 65535) m_err_cnt++;
        end
        $display("beat sof=%0b data=%h ok=%0b err=%0b exp_id=%0d retry=%0b",
                 s, d, frame_ok, frame_err, exp_id, retry_req);
        check_outs(1'b1, s, tail ? (d & ~64'hFFF) : d, ok, err);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            data_vld = 1'b0;
            @(posedge clk);
            #1;
            check_outs(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        end
    endtask

    // Sends the first nbeats of fr; a truncated frame is aborted by the next sof
    task automatic send_frame(input int gap, input int nbeats);
        bit is_data;
        bit pass;
        bit ab;
        bit tail;
        is_data = (fr[0][63:62] == 2'b01);
        pass    = (fr[3][11:0] == (frame_crc() ^ {4'b0, m_exp_id}));
        for (int b = 0; b < nbeats; b++) begin
            ab   = (b == 0) && m_abort_pending;
            tail = (b == 3);
            beat(b == 0, fr[b], tail, tail && pass, ab || (tail && !pass), is_data);
            if (b == 0) m_abort_pending = 1'b0;
            if (b < nbeats - 1 && gap > 0) idle(gap);
        end
        if (nbeats < 4) m_abort_pending = 1'b1;
    endtask

    initial begin
        int f;
        int r;
        int bsel;
        int pos;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outs(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("reset_data_out", data_out, 64'h0);
        rst = 1'b0;
        idle(2);

        // Three good data frames
        for (int i = 0; i < 3; i++) begin
            build_frame(2'b01, 8'(i));
            send_frame(0, 4);
        end
        chk("exp_id_after_3", exp_id, 64'd3);

        // Bring exp_id to 5, then corrupt bit 40 of beat 2 and resend intact
        build_frame(2'b01, 8'd3); send_frame(0, 4);
        build_frame(2'b01, 8'd4); send_frame(0, 4);
        build_frame(2'b01, 8'd5);
        for (int b = 0; b < 4; b++) saved[b] = fr[b];
        fr[2][40] = ~fr[2][40];
        send_frame(0, 4);
        chk("retry_after_flip", retry_req, 64'd1);
        for (int b = 0; b < 4; b++) fr[b] = saved[b];
        send_frame(1, 4);
        chk("exp_id_after_resend", exp_id, 64'd6);

        // Id skip, then a control frame while retrying, then the right id
        build_frame(2'b01, 8'd7); send_frame(0, 4);
        build_frame(2'b10, m_exp_id); send_frame(0, 4);
        chk("retry_after_ctrl", retry_req, 64'd1);
        build_frame(2'b01, 8'd6); send_frame(0, 4);

        // Abort: sof arrives where beat 2 would be
        build_frame(2'b01, 8'd7); send_frame(0, 2);
        build_frame(2'b01, 8'd7); send_frame(0, 4);
        // Beat outside any frame is forwarded unmodified
        beat(1'b0, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 1'b0);

        // Gapped frames: one good, one corrupted, one recovering
        build_frame(2'b01, 8'd8); send_frame(3, 4);
        build_frame(2'b01, 8'd9); fr[1][5] = ~fr[1][5]; send_frame(3, 4);
        build_frame(2'b01, 8'd9); send_frame(3, 4);

        // Random traffic until exp_id wraps past 0xFF
        f = 0;
        while ((!wrapped || f < 20) && f < 700) begin
            r = $urandom_range(0, 7);
            build_frame((r == 0) ? 2'b10 : 2'b01, m_exp_id);
            if (r == 1) begin
                bsel = $urandom_range(0, 3);
                pos  = $urandom_range(0, 63);
                fr[bsel][pos] = ~fr[bsel][pos];
            end
            send_frame($urandom_range(0, 1), 4);
            f++;
        end
        chk("wrap_reached", {63'b0, wrapped}, 64'd1);

        // Reset during beat 1 clears everything immediately
        build_frame(2'b01, m_exp_id);
        beat(1'b1, fr[0], 1'b0, 1'b0, 1'b0, 1'b1);
        data_vld = 1'b1;
        data_in  = fr[1];
        #2;
        rst = 1'b1;
        #1;
        m_exp_id = '0;
        m_retry  = 1'b0;
        m_err_cnt = 0;
        m_abort_pending = 1'b0;
        check_outs(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("rst_data_out", data_out, 64'h0);
        data_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        build_frame(2'b01, 8'd0);
        send_frame(0, 4);
        chk("exp_id_after_rst_frame", exp_id, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
